alu_sweep_driver: RTL and testbench

ALU_SWEEP_DRIVER -- requirements
Module: alu_sweep_driver

---
 rtl/alu_sweep_driver_pkg.sv | 33 +++
 rtl/alu_sweep_driver_valid_pipe.sv | 42 ++++
 rtl/alu_sweep_driver.sv | 156 +++++++++++++++
 tb/tb_alu_sweep_driver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sweep_driver_pkg.sv
// alu_sweep_driver_pkg
// Shared definitions for the ALU sweep driver:
//   sweep_state_e  - sweep controller states
//   FLAG_*         - bit positions inside alu_flags
//   SIG_W / RES_W  - signature width and the result field width inside it
//   CNT_SAT        - value at which the flag counters stop
//   sat_inc()      - saturating increment for the flag counters
package alu_sweep_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;

    localparam int SIG_W = 16;
    // The flags occupy the top nibble of the signature term; the result is
    // zero-extended into the remaining bits.
    localparam int RES_W = SIG_W - 4;

    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_SAT) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_sweep_driver_valid_pipe.sv
// sweep_valid_pipe
// LAT-deep shift register marking which cycles carry a harness result that
// belongs to a driven vector.
// Ports:
//   i_clk, i_reset  clock, synchronous active-low reset (empties the line)
//   i_valid         a vector is being driven this cycle
//   o_valid         the result of a vector driven LAT cycles ago is present
//   o_last          no entry other than the oldest stage is occupied, so the
//                   line is empty after this cycle if nothing new enters
module sweep_valid_pipe #(
    parameter int LAT = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_valid,
    output logic o_valid,
    output logic o_last
);

    localparam logic [LAT-1:0] ALL_ONES  = '1;
    localparam logic [LAT-1:0] HEAD_MASK = ALL_ONES >> 1;

    logic [LAT-1:0] r_pipe;

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge i_clk) begin
                if (!i_reset) r_pipe <= '0;
                else          r_pipe <= i_valid;
            end
        end else begin : g_shift
            always_ff @(posedge i_clk) begin
                if (!i_reset) r_pipe <= '0;
                else          r_pipe <= {r_pipe[LAT-2:0], i_valid};
            end
        end
    endgenerate

    assign o_valid = r_pipe[LAT-1];
    assign o_last  = ((r_pipe & HEAD_MASK) == '0);

endmodule

// File: rtl/alu_sweep_driver.sv
// alu_sweep_driver
// Drives an exhaustive (A,B) operand sweep into an external ALU harness and
// folds each returned result/flag set into a rotating signature plus
// saturating carry/zero counters.
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   start, op_sel          sweep request (IDLE only) and opcode to sweep
//   A_out, B_out, Sel_out  vector driven to the harness
//   alu_result, alu_flags  harness response, valid LAT cycles after a vector
//   busy, done             busy in DRIVE/DRAIN, one-cycle done pulse
//   signature              rotate-xor checksum of captured responses
//   carry_count, zero_count  saturating counts of captures with that flag
// Build option: ALU_SWEEP_ALL_OPS_EN sweeps Sel_out 0..15 and ignores op_sel.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last sweep's values
// DRIVE | one operand pair per cycle, B fastest
// DRAIN | no new vectors; collecting in-flight results
// DONE  | single-cycle completion pulse, busy low
module alu_sweep_driver
    import alu_sweep_driver_pkg::*;
#(
    parameter int N   = 4,
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op_sel,
    output logic [N-1:0]     A_out,
    output logic [N-1:0]     B_out,
    output logic [3:0]       Sel_out,
    input  logic [N-1:0]     alu_result,
    input  logic [3:0]       alu_flags,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      carry_count,
    output logic [15:0]      zero_count
);

    localparam logic [2*N-1:0] AB_ONE = {{(2*N-1){1'b0}}, 1'b1};

    sweep_state_e     r_state;
    sweep_state_e     w_next_state;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [3:0]       r_sel;
    logic [SIG_W-1:0] r_sig;
    logic [15:0]      r_carry_cnt;
    logic [15:0]      r_zero_cnt;

    logic             w_accept;
    logic             w_issue;
    logic             w_ab_wrap;
    logic             w_last_vec;
    logic             w_cap;
    logic             w_drain_last;
    logic [2*N-1:0]   w_ab_inc;
    logic [SIG_W-1:0] w_sig_next;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_issue   = (r_state == DRIVE);
    assign w_ab_wrap = (r_a == '1) && (r_b == '1);
`ifdef ALU_SWEEP_ALL_OPS_EN
    assign w_last_vec = w_ab_wrap && (r_sel == 4'hF);
`else
    assign w_last_vec = w_ab_wrap;
`endif
    // A and B form one counter with B in the low half, so B runs fastest.
    assign w_ab_inc   = {r_a, r_b} + AB_ONE;
    assign w_sig_next = {r_sig[SIG_W-2:0], r_sig[SIG_W-1]}
                        ^ {alu_flags, RES_W'(alu_result)};

    sweep_valid_pipe #(
        .LAT(LAT)
    ) u_valid_pipe (
        .i_clk   (clk),
        .i_reset (reset),
        .i_valid (w_issue),
        .o_valid (w_cap),
        .o_last  (w_drain_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                if (w_last_vec) w_next_state = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_drain_last) w_next_state = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_sig       <= '0;
            r_carry_cnt <= '0;
            r_zero_cnt  <= '0;
        end else if (w_accept) begin
            r_a         <= '0;
            r_b         <= '0;
`ifdef ALU_SWEEP_ALL_OPS_EN
            r_sel       <= 4'h0;
`else
            r_sel       <= op_sel;
`endif
            r_sig       <= '0;
            r_carry_cnt <= '0;
            r_zero_cnt  <= '0;
        end else begin
            // The final vector stays on the bus through DRAIN and beyond.
            if (w_issue && !w_last_vec) begin
                {r_a, r_b} <= w_ab_inc;
`ifdef ALU_SWEEP_ALL_OPS_EN
                if (w_ab_wrap) r_sel <= r_sel + 4'd1;
`endif
            end
            if (w_cap) begin
                r_sig <= w_sig_next;
                if (alu_flags[FLAG_CARRY]) r_carry_cnt <= sat_inc(r_carry_cnt);
                if (alu_flags[FLAG_ZERO])  r_zero_cnt  <= sat_inc(r_zero_cnt);
            end
        end
    end

    assign A_out       = r_a;
    assign B_out       = r_b;
    assign Sel_out     = r_sel;
    assign signature   = r_sig;
    assign carry_count = r_carry_cnt;
    assign zero_count  = r_zero_cnt;

endmodule

// File: tb/tb_alu_sweep_driver.sv
module tb_alu_sweep_driver;

    localparam int N   = 2;
    localparam int LAT = 2;
`ifdef ALU_SWEEP_ALL_OPS_EN
    localparam int NOPS = 16;
`else
    localparam int NOPS = 1;
`endif
    localparam int VPO   = 1 << (2 * N);
    localparam int V     = NOPS * VPO;
    localparam int SPAN  = V + LAT + 1;
    localparam int MAXO  = (1 << N) - 1;
    localparam int SAT_N = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       op_sel = 4'h0;
    logic [N-1:0]     A_out, B_out;
    logic [3:0]       Sel_out;
    logic [N-1:0]     alu_result = '0;
    logic [3:0]       alu_flags = 4'h0;
    logic             busy, done;
    logic [15:0]      signature, carry_count, zero_count;

    logic             start_sat = 1'b0;
    logic [SAT_N-1:0] a_sat, b_sat;
    logic [3:0]       sel_sat;
    logic             busy_sat, done_sat;
    logic [15:0]      sig_sat, carry_sat, zero_sat;

    alu_sweep_driver #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op_sel(op_sel),
        .A_out(A_out), .B_out(B_out), .Sel_out(Sel_out),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .done(done), .signature(signature),
        .carry_count(carry_count), .zero_count(zero_count)
    );

    alu_sweep_driver #(.N(SAT_N), .LAT(1)) dut_sat (
        .clk(clk), .reset(reset), .start(start_sat), .op_sel(4'h0),
        .A_out(a_sat), .B_out(b_sat), .Sel_out(sel_sat),
        .alu_result({SAT_N{1'b0}}), .alu_flags(4'b0011),
        .busy(busy_sat), .done(done_sat), .signature(sig_sat),
        .carry_count(carry_sat), .zero_count(zero_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural ALU harness: response is a hash of the vector it was given.
    int          mode = 0;
    int          next_mode = 0;
    logic [31:0] seed = 32'h0;

    function automatic logic [N+3:0] harness(input int a, input int b, input int sel,
                                             input int md, input logic [31:0] sd);
        logic [31:0] h;
        h = ((32'(sel) << 16) | (32'(a) << 8) | 32'(b)) ^ sd;
        h = h * 32'h9E3779B1;
        h = h ^ (h >> 13);
        case (md)
            1:       return {4'b0010, {N{1'b0}}};
            2:       return {h[27:26], 1'b1, h[24], h[N-1:0]};
            default: return {h[27:24], h[N-1:0]};
        endcase
    endfunction

    int hist_a[LAT+1];
    int hist_b[LAT+1];
    int hist_s[LAT+1];

    always @(negedge clk) begin
        for (int i = LAT; i > 0; i--) begin
            hist_a[i] = hist_a[i-1];
            hist_b[i] = hist_b[i-1];
            hist_s[i] = hist_s[i-1];
        end
        hist_a[0] = int'(A_out);
        hist_b[0] = int'(B_out);
        hist_s[0] = int'(Sel_out);
        {alu_flags, alu_result} = harness(hist_a[LAT], hist_b[LAT], hist_s[LAT], mode, seed);
    end

    // Reference model: expected outcome of one whole sweep.
    typedef struct {
        int          s;
        int          d;
        logic [3:0]  op;
        logic [15:0] sig;
        logic [15:0] cc;
        logic [15:0] zc;
    } exp_t;

    function automatic exp_t predict(input int s, input logic [3:0] op,
                                     input int md, input logic [31:0] sd);
        exp_t         e;
        logic [N+3:0] r;
        logic [15:0]  term;
        int           ncar, nzero, sel, a, b;
        e.s = s; e.d = s + SPAN; e.op = op; e.sig = 16'h0;
        ncar = 0; nzero = 0;
        for (int k = 0; k < V; k++) begin
            sel  = (NOPS > 1) ? k / VPO : int'(op);
            a    = (k % VPO) / (1 << N);
            b    = k % (1 << N);
            r    = harness(a, b, sel, md, sd);
            term = (16'(r[N+3:N]) << 12) | 16'(r[N-1:0]);
            e.sig = ((e.sig << 1) | (e.sig >> 15)) ^ term;
            ncar  += int'(r[N]);
            nzero += int'(r[N+1]);
        end
        e.cc = (ncar  > 65535) ? 16'hFFFF : 16'(ncar);
        e.zc = (nzero > 65535) ? 16'hFFFF : 16'(nzero);
        return e;
    endfunction

    exp_t               sb[$];
    int                 idle_from = 0;
    bit                 mon_en = 1'b0;
    logic [15:0]        last_sig = 16'h0, last_cc = 16'h0, last_zc = 16'h0;
    logic [2*N+3:0]     last_vec = '0;

    task automatic step(input logic st, input logic rst_n);
        exp_t e;
        @(negedge clk); #1;
        reset  = rst_n;
        start  = st;
        op_sel = 4'($urandom_range(0, 15));
        if (!rst_n) begin
            sb.delete();
            idle_from = cyc + 1;
            last_sig = 16'h0; last_cc = 16'h0; last_zc = 16'h0; last_vec = '0;
        end else if (st && cyc >= idle_from) begin
            mode = next_mode;
            seed = $urandom;
            e = predict(cyc, op_sel, mode, seed);
            sb.push_back(e);
            idle_from = e.d + 1;
        end
    endtask

    // Monitor: compares every cycle against the oldest outstanding sweep.
    always @(negedge clk) begin
        exp_t e;
        int   k, a, b, sel;
        if (mon_en) begin
            if (sb.size() == 0 || cyc <= sb[0].s) begin
                check("idle_busy", 64'(busy), 64'(0));
                check("idle_done", 64'(done), 64'(0));
                check("hold_signature", 64'(signature), 64'(last_sig));
                check("hold_carry_count", 64'(carry_count), 64'(last_cc));
                check("hold_zero_count", 64'(zero_count), 64'(last_zc));
                check("hold_vector", 64'({A_out, B_out, Sel_out}), 64'(last_vec));
            end else begin
                e = sb[0];
                if (cyc < e.d) begin
                    check("run_busy", 64'(busy), 64'(1));
                    check("run_done", 64'(done), 64'(0));
                    if (cyc <= e.s + V) begin
                        k   = cyc - e.s - 1;
                        a   = (k % VPO) / (1 << N);
                        b   = k % (1 << N);
                        sel = (NOPS > 1) ? k / VPO : int'(e.op);
                        check("drive_vector", 64'({A_out, B_out, Sel_out}),
                              64'({N'(a), N'(b), 4'(sel)}));
                    end else begin
                        check("drain_vector_hold", 64'({A_out, B_out, Sel_out}),
                              64'({N'(MAXO), N'(MAXO), 4'((NOPS > 1) ? 15 : int'(e.op))}));
                    end
                end else begin
                    check("done_pulse", 64'(done), 64'(1));
                    check("done_busy_low", 64'(busy), 64'(0));
                    check("done_signature", 64'(signature), 64'(e.sig));
                    check("done_carry_count", 64'(carry_count), 64'(e.cc));
                    check("done_zero_count", 64'(zero_count), 64'(e.zc));
                    last_sig = e.sig; last_cc = e.cc; last_zc = e.zc;
                    last_vec = {N'(MAXO), N'(MAXO), 4'((NOPS > 1) ? 15 : int'(e.op))};
                    void'(sb.pop_front());
                end
            end
        end
    end

    bit          sat_seen = 1'b0;
    int          sat_cyc = 0;
    int          s_sat = 0;
    logic [15:0] sat_exp_sig = 16'h0;

    always @(negedge clk) begin
        if (mon_en && done_sat && !sat_seen) begin
            sat_seen = 1'b1;
            sat_cyc  = cyc;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_A_out"}, 64'(A_out), 64'(0));
        check({tag, "_B_out"}, 64'(B_out), 64'(0));
        check({tag, "_Sel_out"}, 64'(Sel_out), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_signature"}, 64'(signature), 64'(0));
        check({tag, "_carry_count"}, 64'(carry_count), 64'(0));
        check({tag, "_zero_count"}, 64'(zero_count), 64'(0));
        check({tag, "_sat_busy"}, 64'(busy_sat), 64'(0));
        check({tag, "_sat_carry"}, 64'(carry_sat), 64'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        mon_en = 1'b1;
        step(1'b0, 1'b1);

        // Plain sweep with hashed responses.
        next_mode = 0;
        step(1'b1, 1'b1);
        repeat (SPAN + 2) step(1'b0, 1'b1);

        // Zero flag on every capture, result zero.
        next_mode = 1;
        step(1'b1, 1'b1);
        repeat (SPAN + 2) step(1'b0, 1'b1);
        check("zero_mode_zero_count", 64'(zero_count), 64'(V));
        check("zero_mode_carry_count", 64'(carry_count), 64'(0));

        // Start held high across a whole sweep and into the next one.
        next_mode = 0;
        repeat (26) step(1'b1, 1'b1);
        repeat (SPAN + 2) step(1'b0, 1'b1);

        // Random start requests, many landing while busy.
        for (int i = 0; i < 4 * (SPAN + 2); i++) begin
            next_mode = $urandom_range(0, 2);
            step(1'($urandom_range(0, 3) == 0), 1'b1);
        end
        repeat (SPAN + 2) step(1'b0, 1'b1);

        // Reset in the middle of a sweep, then a complete sweep.
        next_mode = 2;
        step(1'b1, 1'b1);
        repeat (V / 2 + 2) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_all_zero("midsweep_reset");
        next_mode = 0;
        step(1'b1, 1'b1);
        repeat (SPAN + 2) step(1'b0, 1'b1);

`ifndef ALU_SWEEP_ALL_OPS_EN
        // 65536 captures with carry and zero set: counters must stop at FFFF.
        sat_exp_sig = 16'h0;
        for (int i = 0; i < (1 << (2 * SAT_N)); i++)
            sat_exp_sig = ((sat_exp_sig << 1) | (sat_exp_sig >> 15)) ^ 16'h3000;
        @(negedge clk); #1;
        start = 1'b0; start_sat = 1'b1; s_sat = cyc;
        @(negedge clk); #1;
        start_sat = 1'b0;
        for (int i = 0; i < (1 << (2 * SAT_N)) + 16 && !sat_seen; i++) step(1'b0, 1'b1);
        check("sat_done_seen", 64'(sat_seen), 64'(1));
        check("sat_done_cycle", 64'(sat_cyc), 64'(s_sat + (1 << (2 * SAT_N)) + 2));
        check("sat_carry_count", 64'(carry_sat), 64'(16'hFFFF));
        check("sat_zero_count", 64'(zero_sat), 64'(16'hFFFF));
        check("sat_signature", 64'(sig_sat), 64'(sat_exp_sig));
`endif

        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
